// File: rtl/decoder_arb_ctrl.sv
// decoder_arb_ctrl: round-robin arbiter and sequencer that shares one
// decoder_proj core among NREQ requesters and returns tagged results.
// Optional WAIT-state timeout is compiled in with `define DEC_ARB_TIMEOUT_EN.
module decoder_arb_ctrl #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*7-1:0] req_code,
    output logic [NREQ-1:0]   req_ready,
    output logic              dec_start,
    output logic [6:0]        dec_code,
    input  logic              dec_done,
    input  logic [OUT_W-1:0]  dec_data,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [OUT_W-1:0]  rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int unsigned NREQ_U = NREQ;

    if (NREQ < 2 || NREQ > 8 || ID_W != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_cfg
        $error("decoder_arb_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic            found;
    logic [ID_W-1:0] win;
    logic [6:0]      sel_code;
    int unsigned     win_idx;
    int unsigned     idx;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    assign cnt_next = cnt + 1'b1;
`endif

    // Rotating-priority search: first valid requester above the last one served
    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            idx = (32'(ptr) + i) % NREQ_U;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
        win      = win_idx[ID_W-1:0];
        sel_code = req_code[7*win_idx +: 7];
    end

    // One-hot accept strobe, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !wb_rst_i) begin
            req_ready[win] = 1'b1;
        end
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            ptr       <= ID_W'(NREQ - 1);
            dec_start <= 1'b0;
            dec_code  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            dec_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        dec_code  <= sel_code;
                        rsp_id    <= win;
                        dec_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef DEC_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (dec_done) begin
                        rsp_data  <= dec_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`ifdef DEC_ARB_TIMEOUT_EN
                    // cnt_next is the count this cycle reaches; hitting TIMEOUT aborts
                    else if (cnt_next == CNT_W'(TIMEOUT)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt_next;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= rsp_id;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_arb_ctrl.sv
// Scoreboard bench for decoder_arb_ctrl: a transaction-timeline model pushes
// expected responses at accept time; a negedge monitor compares and pops.
module tb_decoder_arb_ctrl;

    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int OUT_W   = 8;
    localparam int TIMEOUT = 15;
`ifdef DEC_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*7-1:0] req_code;
    logic [NREQ-1:0]   req_ready;
    logic              dec_start;
    logic [6:0]        dec_code;
    logic              dec_done;
    logic [OUT_W-1:0]  dec_data;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [OUT_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              rsp_ready;
    logic              busy;

    always #5 wb_clk_i = ~wb_clk_i;

    decoder_arb_ctrl #(
        .NREQ(NREQ), .ID_W(ID_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
        .dec_start(dec_start), .dec_code(dec_code),
        .dec_done(dec_done), .dec_data(dec_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
    );

    typedef struct {
        int id;
        int data;
        int err;
    } rsp_t;

    rsp_t exp_q[$];
    int   grant_log[$];
    int   errors = 0;
    int   checks = 0;

    // expectations published by the stimulus process for the monitor
    logic [NREQ-1:0] exp_ready = '0;
    bit              exp_start = 1'b0;
    bit              exp_busy  = 1'b0;
    bit              exp_rsp_valid = 1'b0;
    logic [6:0]      exp_code  = '0;
    bit              mon_en    = 1'b0;

    // stimulus knobs
    int              valid_mode = 0;   // 0 random, 1 fixed mask, 2 mask cleared on grant
    logic [NREQ-1:0] fixed_mask = '0;
    int              k_delay = -1;
    int              k_data  = -1;
    int              k_hold  = -1;
    int              k_code2 = -1;
    bit              stray_en = 1'b0;

    // transaction timeline model
    int         c = 0;
    int         last_id = NREQ - 1;
    int         cur_id, t_acc, done_at, resp_from, hs_cyc, cur_data, hold_left;
    bit         in_tx = 1'b0;
    logic [6:0] codes [NREQ];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // requester closest above the last served one (circular distance)
    function automatic int pick(logic [NREQ-1:0] v, int last);
        int best, best_d, d;
        best   = -1;
        best_d = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                d = (i - last - 1 + 2 * NREQ) % NREQ;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    task automatic step();
        int w, k;
        @(posedge wb_clk_i);
        #1;
        c++;
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;
        if (in_tx && hs_cyc == c - 1) begin
            in_tx   = 1'b0;
            last_id = cur_id;
        end
        for (int i = 0; i < NREQ; i++) codes[i] = 7'($urandom);
        if (k_code2 >= 0) codes[2] = 7'(k_code2);
        for (int i = 0; i < NREQ; i++) req_code[7*i +: 7] = codes[i];
        req_valid = (valid_mode == 0) ? NREQ'($urandom) : fixed_mask;

        exp_ready = '0;
        if (!in_tx) begin
            w = pick(req_valid, last_id);
            if (w >= 0) begin
                exp_ready[w] = 1'b1;
                in_tx    = 1'b1;
                t_acc    = c;
                cur_id   = w;
                exp_code = codes[w];
                hs_cyc   = -10;
                grant_log.push_back(w);
                if (valid_mode == 2) fixed_mask[w] = 1'b0;
                if (k_delay >= 0) k = k_delay;
                else if (TMO && $urandom_range(0, 7) == 0) k = $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
                else k = $urandom_range(0, 5);
                cur_data = (k_data >= 0) ? k_data : int'($urandom_range(0, 255));
                if (TMO && k >= TIMEOUT) begin
                    done_at   = -1;
                    resp_from = c + 2 + TIMEOUT;
                    exp_q.push_back('{w, 0, 1});
                end else begin
                    done_at   = c + 2 + k;
                    resp_from = done_at + 1;
                    exp_q.push_back('{w, cur_data, 0});
                end
                hold_left = (k_hold >= 0) ? k_hold : int'($urandom_range(0, 3));
            end
        end

        dec_done = 1'b0;
        dec_data = OUT_W'($urandom);
        if (in_tx && c == done_at) begin
            dec_done = 1'b1;
            dec_data = OUT_W'(cur_data);
        end else if (stray_en && !(in_tx && c >= t_acc + 2 && c < resp_from)) begin
            dec_done = ($urandom_range(0, 2) == 0);
        end

        exp_start     = in_tx && c == t_acc + 1;
        exp_busy      = in_tx && c > t_acc;
        exp_rsp_valid = in_tx && c >= resp_from;
        if (exp_rsp_valid) begin
            if (hold_left > 0) begin
                rsp_ready = 1'b0;
                hold_left--;
            end else begin
                rsp_ready = 1'b1;
                hs_cyc    = c;
            end
        end else begin
            rsp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset(int n);
        @(posedge wb_clk_i);
        #1;
        mon_en    = 1'b0;
        wb_rst_i  = 1'b1;
        req_valid = '1;
        dec_done  = 1'b1;
        rsp_ready = 1'b1;
        repeat (n) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_dec_start", 32'(dec_start), 0);
        chk("rst_dec_code",  32'(dec_code), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        chk("rst_rsp_data",  32'(rsp_data), 0);
        chk("rst_rsp_err",   32'(rsp_err), 0);
        chk("rst_busy",      32'(busy), 0);
        in_tx   = 1'b0;
        last_id = NREQ - 1;
        hs_cyc  = -10;
        exp_q.delete();
        grant_log.delete();
        exp_ready = '0;
        exp_start = 1'b0;
        exp_busy  = 1'b0;
        exp_rsp_valid = 1'b0;
    endtask

    task automatic drain();
        valid_mode = 2;
        fixed_mask = '0;
        for (int i = 0; i < 100 && in_tx; i++) step();
        step();
        chk("drain_idle", 32'(in_tx), 0);
    endtask

    // monitor: per-cycle control checks and scoreboard pop on handshake
    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("dec_start", 32'(dec_start), 32'(exp_start));
            if (exp_busy) chk("dec_code", 32'(dec_code), 32'(exp_code));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 required no response at t=%0t", $time);
                end else begin
                    chk("rsp_id",   32'(rsp_id),   32'(exp_q[0].id));
                    chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                    chk("rsp_err",  32'(rsp_err),  32'(exp_q[0].err));
                    if (rsp_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        wb_rst_i  = 1'b1;
        req_valid = '0;
        req_code  = '0;
        dec_done  = 1'b0;
        dec_data  = '0;
        rsp_ready = 1'b0;
        do_reset(2);

        // all requesters busy, instant consumer: grant order 0,1,2,3,0
        valid_mode = 1;
        fixed_mask = '1;
        k_delay    = 0;
        k_hold     = 0;
        repeat (30) step();
        chk("rr_count", 32'(grant_log.size() >= 5), 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            chk("rr_order", 32'(grant_log[i]), 32'(i % NREQ));
        end
        drain();

        // single request from requester 2, result two cycles after dec_start
        valid_mode = 2;
        fixed_mask = 4'b0100;
        k_code2    = 7'b1110010;
        k_delay    = 1;
        k_data     = 8'hA5;
        repeat (10) step();
        chk("single_id", 32'(grant_log[grant_log.size()-1]), 2);
        chk("single_done", 32'(exp_q.size()), 0);
        k_code2 = -1;
        k_data  = -1;
        k_delay = -1;

        // backpressure: consumer stalls 6 cycles on every response
        valid_mode = 1;
        fixed_mask = '1;
        k_hold     = 6;
        repeat (60) step();
        drain();

        // stray completions in IDLE, ISSUE and RESP, random traffic
        stray_en   = 1'b1;
        valid_mode = 0;
        k_hold     = -1;
        repeat (800) step();
        do_reset(1);
        repeat (600) step();
        drain();
        stray_en = 1'b0;

`ifdef DEC_ARB_TIMEOUT_EN
        // decoder silent: abort after TIMEOUT WAIT cycles
        valid_mode = 2;
        fixed_mask = 4'b1000;
        k_delay    = TIMEOUT;
        repeat (25) step();
        chk("tmo_done", 32'(exp_q.size()), 0);
        // completion on the last WAIT cycle still wins
        valid_mode = 2;
        fixed_mask = 4'b0010;
        k_delay    = TIMEOUT - 1;
        k_data     = 8'h3C;
        repeat (25) step();
        chk("tmo_edge_done", 32'(exp_q.size()), 0);
        k_delay = -1;
        k_data  = -1;
        drain();
`endif

        chk("final_queue", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
